// File: rtl/fp_normalize_stage.sv
// fp_normalize_stage: iterative FP16 mantissa normalizer feeding the round/pack stage.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready + in_mantissa[18:0],
//   in_exponent[6:0] (signed), in_sign; out_valid/out_ready + out_mantissa[17:0],
//   out_exponent[4:0], out_sign. Params: SHIFT_STEP = max left shift per cycle.
module fp_normalize_stage #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [18:0] in_mantissa,
  input  logic [6:0]  in_exponent,
  input  logic        in_sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] out_mantissa,
  output logic [4:0]  out_exponent,
  output logic        out_sign
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  logic [1:0]        state_q, state_d;
  logic [18:0]       m_q, m_d;
  logic signed [7:0] e_q, e_d;
  logic              s_q, s_d;
  logic [17:0]       om_q, om_d;
  logic [4:0]        oe_q, oe_d;
  logic              os_q, os_d;

  logic [4:0]        lz;
  logic              found;
  logic [4:0]        sh;
  logic signed [7:0] e_sub;

  logic              go_done;
  logic              cand_zero;
  logic [18:0]       cand_m;
  logic signed [7:0] cand_e;

  // Leading zeros of the 18-bit field below the carry bit.
  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = 17; i >= 0; i--) begin
      if (!found) begin
        if (m_q[i]) found = 1'b1;
        else        lz    = lz + 5'd1;
      end
    end
  end

  assign sh    = (lz < STEP) ? lz : STEP;
  assign e_sub = e_q - $signed({3'b000, sh});

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    e_d       = e_q;
    s_d       = s_q;
    om_d      = om_q;
    oe_d      = oe_q;
    os_d      = os_q;
    go_done   = 1'b0;
    cand_zero = 1'b0;
    cand_m    = m_q;
    cand_e    = e_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          m_d     = in_mantissa;
          e_d     = {in_exponent[6], in_exponent};
          s_d     = in_sign;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (m_q[18]) begin
          // Carry: shift right once, folding the lost bit into sticky.
          cand_m  = {1'b0, m_q[18:2], m_q[1] | m_q[0]};
          cand_e  = e_q + 8'sd1;
          go_done = 1'b1;
        end else if (m_q == '0) begin
          cand_zero = 1'b1;
          go_done   = 1'b1;
        end else if (m_q[17]) begin
          go_done = 1'b1;
        end else if (e_sub < 8'sd1) begin
          cand_zero = 1'b1;
          go_done   = 1'b1;
        end else begin
          cand_m  = m_q << sh;
          cand_e  = e_sub;
          go_done = (sh == lz);
        end
        m_d = cand_m;
        e_d = cand_e;
        if (go_done) begin
          state_d = S_DONE;
          os_d    = s_q;
          if (cand_zero || cand_e <= 8'sd0) begin
            om_d = '0;
            oe_d = '0;
          end else if (cand_e >= 8'sd31) begin
            om_d = '0;
            oe_d = 5'd31;
          end else begin
            om_d = cand_m[17:0];
            oe_d = cand_e[4:0];
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      e_q     <= '0;
      s_q     <= 1'b0;
      om_q    <= '0;
      oe_q    <= '0;
      os_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      s_q     <= s_d;
      om_q    <= om_d;
      oe_q    <= oe_d;
      os_q    <= os_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign out_mantissa = om_q;
  assign out_exponent = oe_q;
  assign out_sign     = os_q;

endmodule

// File: tb/tb_fp_normalize_stage.sv
// tb_fp_normalize_stage: directed checks of fp_normalize_stage (SHIFT_STEP=4).
// Hand-computed vectors covering latency, shifting, clamps, backpressure and reset.
module tb_fp_normalize_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [18:0] in_mantissa;
  logic [6:0]  in_exponent;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_mantissa;
  logic [4:0]  out_exponent;
  logic        out_sign;

  int errors = 0;
  int checks = 0;
  int n;
  logic [17:0] hm;
  logic [4:0]  he;
  logic        hs;

  fp_normalize_stage #(.SHIFT_STEP(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mantissa  (in_mantissa),
    .in_exponent  (in_exponent),
    .in_sign      (in_sign),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_mantissa (out_mantissa),
    .out_exponent (out_exponent),
    .out_sign     (out_sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand for one edge; leaves sampling point #1 after accept.
  task automatic offer(input logic [18:0] m, input logic [6:0] e,
                       input logic s);
    in_mantissa = m;
    in_exponent = e;
    in_sign     = s;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid, bounded.
  task automatic wait_out(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  task automatic result(input string tag, input int exp_n,
                        input logic [17:0] em, input logic [4:0] ee,
                        input logic es);
    wait_out(n);
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_valid"}, {31'd0, out_valid}, 1);
    chk({tag, "_man"}, {14'd0, out_mantissa}, {14'd0, em});
    chk({tag, "_exp"}, {27'd0, out_exponent}, {27'd0, ee});
    chk({tag, "_sign"}, {31'd0, out_sign}, {31'd0, es});
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_vld"}, {31'd0, out_valid}, 0);
    chk({tag, "_idle_rdy"}, {31'd0, in_ready}, 1);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_mantissa = '0;
    in_exponent = '0;
    in_sign     = 1'b0;
    out_ready   = 1'b0;
    tick();
    tick();
    chk("rst_rdy", {31'd0, in_ready}, 1);
    chk("rst_vld", {31'd0, out_valid}, 0);
    chk("rst_man", {14'd0, out_mantissa}, 0);
    chk("rst_exp", {27'd0, out_exponent}, 0);
    chk("rst_sign", {31'd0, out_sign}, 0);
    rst_n = 1'b1;
    tick();

    // out_ready pulse in IDLE does nothing
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_ordy_vld", {31'd0, out_valid}, 0);
    chk("idle_ordy_rdy", {31'd0, in_ready}, 1);

    // Normalized passthrough
    offer(19'h2ABCD, 7'd15, 1'b1);
    chk("pass_busy", {31'd0, in_ready}, 0);
    result("pass", 1, 18'h2ABCD, 5'd15, 1'b1);
    release_out("pass");

    // Reset mid-NORM clears held outputs and drops the operand
    offer(19'h00001, 7'd30, 1'b1);
    tick();
    tick();
    chk("mid_vld", {31'd0, out_valid}, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_rdy", {31'd0, in_ready}, 1);
    chk("mrst_vld", {31'd0, out_valid}, 0);
    chk("mrst_man", {14'd0, out_mantissa}, 0);
    chk("mrst_exp", {27'd0, out_exponent}, 0);
    chk("mrst_sign", {31'd0, out_sign}, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mrst_noemit", {31'd0, out_valid}, 0);
    end

    // Carry right-shift with sticky
    offer(19'h40001, 7'd10, 1'b0);
    result("carry", 1, 18'h20001, 5'd11, 1'b0);
    release_out("carry");

    // Multi-cycle left shift: 4,4,4,4,1
    offer(19'h00001, 7'd30, 1'b0);
    result("lshift", 5, 18'h20000, 5'd13, 1'b0);
    release_out("lshift");

    // Two-step shift 0x00C00: lz=6 -> 4 then 2
    offer(19'h00C00, 7'd20, 1'b1);
    result("lsh2", 2, 18'h30000, 5'd14, 1'b1);
    release_out("lsh2");

    // Underflow flush during shifting, sign kept
    offer(19'h00100, 7'd5, 1'b1);
    result("uflow", 2, 18'h0, 5'd0, 1'b1);
    release_out("uflow");

    // Zero mantissa
    offer(19'h00000, 7'd20, 1'b0);
    result("zero", 1, 18'h0, 5'd0, 1'b0);
    release_out("zero");

    // Normalized but negative exponent -> flush
    offer(19'h20000, 7'h7D, 1'b1);
    result("negexp", 1, 18'h0, 5'd0, 1'b1);
    release_out("negexp");

    // Normalized with e=31 -> infinity
    offer(19'h25555, 7'd31, 1'b0);
    result("inf31", 1, 18'h0, 5'd31, 1'b0);
    release_out("inf31");

    // Overflow via carry, then backpressure
    offer(19'h40000, 7'd30, 1'b1);
    result("ovf", 1, 18'h0, 5'd31, 1'b1);
    hm = out_mantissa;
    he = out_exponent;
    hs = out_sign;
    in_mantissa = 19'h2FFFF;
    in_exponent = 7'd3;
    in_sign     = 1'b0;
    in_valid    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_vld", {31'd0, out_valid}, 1);
      chk("bp_rdy", {31'd0, in_ready}, 0);
      chk("bp_man", {14'd0, out_mantissa}, {14'd0, hm});
      chk("bp_exp", {27'd0, out_exponent}, {27'd0, he});
      chk("bp_sign", {31'd0, out_sign}, {31'd0, hs});
    end
    in_valid = 1'b0;
    release_out("bp");
    tick();
    chk("bp_noacc", {31'd0, in_ready}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
